// File: rtl/uart_bus_master_if.sv
// CPU request/response and packed UART register-bus signals for uart_bus_master.
interface uart_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        fault_o;
   logic [31:0] CPU_to_UART;
   logic [31:0] UART_to_CPU;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, UART_to_CPU,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, fault_o, CPU_to_UART
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, UART_to_CPU,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, fault_o, CPU_to_UART
   );
endinterface

// File: rtl/uart_bus_master.sv
// Single-outstanding register-bus initiator: CPU request -> packed AW/W/B or AR/R handshakes,
// with a per-phase timeout that aborts the transaction and sets a sticky fault flag.
module uart_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic               clk,
   input logic               rst,
   uart_bus_master_if.master bus
);
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             aw_q, aw_d, w_q, w_d, b_q, b_d, ar_q, ar_d, r_q, r_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             fault_q, fault_d;
   logic [31:0]      bus_q, bus_d;

   // response-bus unpack
   logic       awready, wready, bvalid, arready, rvalid;
   logic [1:0] bresp, rresp;
   logic [7:0] rdata;
   logic       unused_u2c;
   assign awready    = bus.UART_to_CPU[0];
   assign wready     = bus.UART_to_CPU[1];
   assign bvalid     = bus.UART_to_CPU[2];
   assign bresp      = bus.UART_to_CPU[4:3];
   assign arready    = bus.UART_to_CPU[5];
   assign rvalid     = bus.UART_to_CPU[6];
   assign rresp      = bus.UART_to_CPU[8:7];
   assign rdata      = bus.UART_to_CPU[16:9];
   assign unused_u2c = ^bus.UART_to_CPU[31:17];

   logic timeout;
   assign timeout = (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      aw_d          = aw_q;
      w_d           = w_q;
      b_d           = 1'b0;
      ar_d          = 1'b0;
      r_d           = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = 8'd0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      fault_d       = fault_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            aw_d  = 1'b0;
            w_d   = 1'b0;
            if (bus.req_valid && req_ready_q) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (bus.req_we) begin
                  state_d = WR_AW_W;
                  aw_d    = 1'b1;
                  w_d     = 1'b1;
               end else begin
                  state_d = RD_AR;
                  ar_d    = 1'b1;
               end
            end
         end
         WR_AW_W: begin
            aw_d = aw_q && !awready;
            w_d  = w_q && !wready;
            if (!aw_d && !w_d) begin
               state_d = WR_B;
               b_d     = 1'b1;
               cnt_d   = '0;
            end else if ((aw_q && awready) || (w_q && wready)) begin
               cnt_d = '0;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         WR_B: begin
            b_d = 1'b1;
            if (bvalid) begin
               state_d     = IDLE;
               b_d         = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (bresp != 2'd0);
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         RD_AR: begin
            ar_d = 1'b1;
            if (arready) begin
               state_d = RD_R;
               ar_d    = 1'b0;
               r_d     = 1'b1;
               cnt_d   = '0;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         RD_R: begin
            r_d = 1'b1;
            if (rvalid) begin
               state_d     = IDLE;
               r_d         = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (rresp != 2'd0);
               rsp_rdata_d = (rresp != 2'd0) ? 8'd0 : rdata;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // timeout abort: a stalled phase fell back to IDLE without a response
      if (state_q != IDLE && state_d == IDLE && !rsp_valid_d) begin
         aw_d          = 1'b0;
         w_d           = 1'b0;
         b_d           = 1'b0;
         ar_d          = 1'b0;
         r_d           = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_err_d     = 1'b1;
         rsp_timeout_d = 1'b1;
         rsp_rdata_d   = 8'd0;
         fault_d       = 1'b1;
      end
      if (state_d == IDLE) cnt_d = '0;

      req_ready_d = (state_d == IDLE);
      // address/data fields only carry a value while their valid is up
      bus_d = {12'd0, r_d, ar_d ? addr_d : 3'd0, ar_d, 1'b0,
               w_d ? wdata_d : 8'd0, b_d, aw_d ? addr_d : 3'd0, w_d, aw_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         addr_q        <= 3'd0;
         wdata_q       <= 8'd0;
         aw_q          <= 1'b0;
         w_q           <= 1'b0;
         b_q           <= 1'b0;
         ar_q          <= 1'b0;
         r_q           <= 1'b0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 8'd0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         fault_q       <= 1'b0;
         bus_q         <= 32'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         aw_q          <= aw_d;
         w_q           <= w_d;
         b_q           <= b_d;
         ar_q          <= ar_d;
         r_q           <= r_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         fault_q       <= fault_d;
         bus_q         <= bus_d;
      end
   end

   logic unused_flops;
   assign unused_flops = b_q ^ ar_q ^ r_q;

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.fault_o     = fault_q;
   assign bus.CPU_to_UART = bus_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master with a hand-driven UART responder.
module tb_uart_bus_master;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   uart_bus_master_if bus ();

   uart_bus_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // UART_to_CPU bit masks
   localparam logic [31:0] AWREADY = 32'h1;
   localparam logic [31:0] WREADY  = 32'h2;
   localparam logic [31:0] BVALID  = 32'h4;
   localparam logic [31:0] ARREADY = 32'h20;
   localparam logic [31:0] RVALID  = 32'h40;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic we, input logic [2:0] addr, input logic [7:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
   endtask

   logic [31:0] c2u;
   assign c2u = bus.CPU_to_UART;

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_we      = 1'b0;
      bus.req_addr    = 3'd0;
      bus.req_wdata   = 8'd0;
      bus.UART_to_CPU = 32'd0;
      #12;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_c2u", c2u, 32'd0);
      check("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.fault_o}, 32'd0);
      rst = 1'b0;
      tick();

      // zero-wait write addr=3 wdata=0x83
      bus.UART_to_CPU = AWREADY | WREADY | BVALID;
      request(1'b1, 3'd3, 8'h83);
      check("wr0_c2u_n", c2u, 32'h0000_20CF);
      check("wr0_ready_busy", 32'(bus.req_ready), 32'd0);
      tick();
      check("wr0_c2u_b", c2u, 32'h0000_0020);
      check("wr0_rsp_early", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("wr0_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.req_ready}, 32'b101);
      check("wr0_c2u_idle", c2u, 32'd0);
      tick();
      check("wr0_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

      // write with wready 4 cycles after awready
      bus.UART_to_CPU = AWREADY;
      request(1'b1, 3'd6, 8'h5A);
      check("wr1_both", c2u, 32'h0000_169B);
      tick();
      bus.UART_to_CPU = 32'd0;
      for (int i = 0; i < 3; i++) begin
         check("wr1_w_held", c2u, 32'h0000_1682);
         check("wr1_no_rsp", 32'(bus.rsp_valid), 32'd0);
         tick();
      end
      check("wr1_w_held4", c2u, 32'h0000_1682);
      bus.UART_to_CPU = WREADY | BVALID;
      tick();
      check("wr1_b", c2u, 32'h0000_0020);
      tick();
      check("wr1_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'b10);
      tick();
      check("wr1_one_rsp", 32'(bus.rsp_valid), 32'd0);

      // read addr=5, rdata=0x60 after 2 wait cycles
      bus.UART_to_CPU = ARREADY;
      request(1'b0, 3'd5, 8'h00);
      check("rd0_ar", c2u, 32'h0005_8000);
      tick();
      bus.UART_to_CPU = 32'd0;
      check("rd0_r", c2u, 32'h0008_0000);
      tick();
      tick();
      check("rd0_wait", {30'd0, bus.rsp_valid, c2u[19]}, 32'b01);
      bus.UART_to_CPU = RVALID | (32'h60 << 9);
      tick();
      check("rd0_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0000_0260);
      check("rd0_c2u_idle", c2u, 32'd0);
      tick();

      // read with rresp=2
      bus.UART_to_CPU = ARREADY | RVALID | (32'd2 << 7) | (32'hA5 << 9);
      request(1'b0, 3'd1, 8'h00);
      tick();
      tick();
      check("rd1_rsp", {21'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
            32'h0000_0600);
      tick();

      // arready never comes: timeout after 8 cycles
      bus.UART_to_CPU = 32'd0;
      request(1'b0, 3'd2, 8'h00);
      for (int i = 0; i < 7; i++) begin
         check("to_ar_held", c2u, 32'h0002_8000);
         tick();
      end
      check("to_ar_last", c2u, 32'h0002_8000);
      check("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("to_c2u_drop", c2u, 32'd0);
      check("to_rsp", {20'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.fault_o,
                       bus.rsp_rdata}, 32'h0000_0F00);
      tick();
      check("to_fault_sticky", {30'd0, bus.rsp_valid, bus.fault_o}, 32'b01);

      // next request after timeout still runs
      bus.UART_to_CPU = AWREADY | WREADY | BVALID;
      request(1'b1, 3'd4, 8'h11);
      tick();
      tick();
      check("post_to_rsp", {28'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.fault_o},
            32'b1001);
      tick();

      // reset while waiting in WR_B
      bus.UART_to_CPU = AWREADY | WREADY;
      request(1'b1, 3'd7, 8'hC3);
      tick();
      check("rs_bready", 32'(c2u[5]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rs_c2u_async", c2u, 32'd0);
      check("rs_state", {28'd0, bus.rsp_valid, bus.req_ready, bus.fault_o, bus.rsp_err},
            32'b0100);
      #4 rst = 1'b0;
      bus.UART_to_CPU = BVALID;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rs_no_rsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
